// File: rtl/pipe_hazard_ctrl.sv
// Stage controller for the 5-stage MIPS pipeline: RAW stalls, branch flush, data-memory wait,
// warm-up. Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter bit          WB_STALL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr_id,
    input  logic [4:0]  rt_addr_id,
    input  logic        rs_used_id,
    input  logic        rt_used_id,
    input  logic [4:0]  regw_addr_exe,
    input  logic        wb_wen_exe,
    input  logic [4:0]  regw_addr_mem,
    input  logic        wb_wen_mem,
    input  logic [4:0]  regw_addr_wb,
    input  logic        wb_wen_wb,
    input  logic        is_branch_mem,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        dmem_ack,
    output logic        if_rst,
    output logic        id_rst,
    output logic        exe_rst,
    output logic        mem_rst,
    output logic        wb_rst,
    output logic        if_en,
    output logic        id_en,
    output logic        exe_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        stall,
    output logic        dmem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_raw,
    output logic [31:0] perf_stall_dmem,
    output logic [15:0] perf_flush
`endif
);

    typedef enum logic [1:0] {StInit, StRun, StDwait} state_t;
    typedef enum logic [2:0] {ModeReset, ModeWait, ModeFlush, ModeRaw, ModeRun} mode_t;

    localparam logic [7:0] InitLast = 8'(RST_CYCLES - 1);
    localparam logic [7:0] ToLast   = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    mode_t      mode, mode_adv;
    logic [7:0] cnt_q, cnt_d;
    logic       err_d;
    logic       hit_rs, hit_rt, data_wait;

    function automatic logic raw_hit(input logic [4:0] a, input logic used);
        return used && (a != 5'd0) &&
               ((wb_wen_exe && regw_addr_exe == a) ||
                (wb_wen_mem && regw_addr_mem == a) ||
                (WB_STALL && wb_wen_wb && regw_addr_wb == a));
    endfunction

    assign hit_rs    = raw_hit(rs_addr_id, rs_used_id);
    assign hit_rt    = raw_hit(rt_addr_id, rt_used_id);
    assign data_wait = mem_valid && (mem_ren || mem_wen) && !dmem_ack;

    // Resolution once no data access is outstanding
    assign mode_adv = (mem_valid && is_branch_mem) ? ModeFlush :
                      (hit_rs || hit_rt)           ? ModeRaw   : ModeRun;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = dmem_err;
        mode    = ModeReset;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == InitLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (data_wait) begin
                    mode    = ModeWait;
                    state_d = StDwait;
                    cnt_d   = '0;
                end else begin
                    mode = mode_adv;
                end
            end
            StDwait: begin
                if (dmem_ack || cnt_q == ToLast) begin
                    // A timed-out access is abandoned and the pipe advances as if acked
                    mode    = mode_adv;
                    state_d = StRun;
                    cnt_d   = '0;
                    if (!dmem_ack) err_d = 1'b1;
                end else begin
                    mode  = ModeWait;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            dmem_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dmem_err <= err_d;
        end
    end

    always_comb begin
        {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
        {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
        stall = 1'b0;
        unique case (mode)
            ModeReset: begin
                {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
                stall = 1'b1;
            end
            ModeWait: begin
                wb_rst = 1'b1;
                stall  = 1'b1;
            end
            ModeFlush: begin
                {id_rst, exe_rst, mem_rst} = 3'b111;
                if_en = 1'b1;
                wb_en = 1'b1;
            end
            ModeRaw: begin
                exe_rst = 1'b1;
                mem_en  = 1'b1;
                wb_en   = 1'b1;
                stall   = 1'b1;
            end
            default: {if_en, id_en, exe_en, mem_en, wb_en} = 5'b11111;
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_raw  <= '0;
            perf_stall_dmem <= '0;
            perf_flush      <= '0;
        end else begin
            if (mode == ModeRaw && perf_stall_raw != '1) perf_stall_raw <= perf_stall_raw + 32'd1;
            if (mode == ModeWait && perf_stall_dmem != '1) begin
                perf_stall_dmem <= perf_stall_dmem + 32'd1;
            end
            if (mode == ModeFlush && perf_flush != '1) perf_flush <= perf_flush + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (WB_STALL=1 and 0) share stimulus.
module tb_pipe_hazard_ctrl;

    localparam logic [10:0] RST_O   = {5'b11111, 5'b00000, 1'b1};
    localparam logic [10:0] RUN_O   = {5'b00000, 5'b11111, 1'b0};
    localparam logic [10:0] WAIT_O  = {5'b00001, 5'b00000, 1'b1};
    localparam logic [10:0] FLUSH_O = {5'b01110, 5'b10001, 1'b0};
    localparam logic [10:0] RAW_O   = {5'b00100, 5'b00011, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs_addr_id, rt_addr_id, regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic       rs_used_id, rt_used_id, wb_wen_exe, wb_wen_mem, wb_wen_wb;
    logic       is_branch_mem, mem_valid, mem_ren, mem_wen, dmem_ack;

    logic [11:0] act, act0;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] p_raw, p_dmem, p_raw0, p_dmem0;
    logic [15:0] p_fl, p_fl0;
`endif

    pipe_hazard_ctrl #(.RST_CYCLES(4), .TIMEOUT(8), .WB_STALL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .is_branch_mem(is_branch_mem), .mem_valid(mem_valid),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .dmem_ack(dmem_ack),
        .if_rst(act[11]), .id_rst(act[10]), .exe_rst(act[9]), .mem_rst(act[8]), .wb_rst(act[7]),
        .if_en(act[6]), .id_en(act[5]), .exe_en(act[4]), .mem_en(act[3]), .wb_en(act[2]),
        .stall(act[1]), .dmem_err(act[0])
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall_raw(p_raw), .perf_stall_dmem(p_dmem), .perf_flush(p_fl)
`endif
    );

    pipe_hazard_ctrl #(.RST_CYCLES(4), .TIMEOUT(8), .WB_STALL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
        .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
        .is_branch_mem(is_branch_mem), .mem_valid(mem_valid),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .dmem_ack(dmem_ack),
        .if_rst(act0[11]), .id_rst(act0[10]), .exe_rst(act0[9]), .mem_rst(act0[8]),
        .wb_rst(act0[7]), .if_en(act0[6]), .id_en(act0[5]), .exe_en(act0[4]),
        .mem_en(act0[3]), .wb_en(act0[2]), .stall(act0[1]), .dmem_err(act0[0])
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall_raw(p_raw0), .perf_stall_dmem(p_dmem0), .perf_flush(p_fl0)
`endif
    );

    typedef struct {
        int          id;
        logic [11:0] o;
        logic [11:0] o0;
        logic [31:0] e_raw;
        logic [31:0] e_dmem;
        logic [15:0] e_fl;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   vec_id = 0;
    logic m_err  = 1'b0;
    int   m_raw  = 0;
    int   m_dmem = 0;
    int   m_fl   = 0;

    // Expected perf values are the counts of earlier cycles; reset cycles clear them
    task automatic push(input logic [10:0] o, input logic [10:0] o0);
        exp_t e;
        if (o == RST_O) begin
            m_raw = 0; m_dmem = 0; m_fl = 0;
        end
        e.id     = vec_id;
        e.o      = {o, m_err};
        e.o0     = {o0, m_err};
        e.e_raw  = 32'(m_raw);
        e.e_dmem = 32'(m_dmem);
        e.e_fl   = 16'(m_fl);
        q.push_back(e);
        vec_id++;
        if (o == RAW_O)   m_raw++;
        if (o == WAIT_O)  m_dmem++;
        if (o == FLUSH_O) m_fl++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        {rs_addr_id, rt_addr_id, regw_addr_exe, regw_addr_mem, regw_addr_wb} = '0;
        {rs_used_id, rt_used_id, wb_wen_exe, wb_wen_mem, wb_wen_wb} = '0;
        {is_branch_mem, mem_valid, mem_ren, mem_wen, dmem_ack} = '0;
    endtask

    task automatic mem_acc(input logic ack, input logic br);
        mem_valid = 1'b1; mem_ren = 1'b1; dmem_ack = ack; is_branch_mem = br;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_vec++;
            if (act !== mon_e.o || act0 !== mon_e.o0) begin
                n_fail++;
                $display("FAIL vec%0d stage outputs: got %b/%b expected %b/%b",
                         mon_e.id, act, act0, mon_e.o, mon_e.o0);
            end
`ifdef PIPE_PERF_CNT_EN
            n_vec++;
            if (p_raw !== mon_e.e_raw || p_dmem !== mon_e.e_dmem || p_fl !== mon_e.e_fl) begin
                n_fail++;
                $display("FAIL vec%0d perf: got %0d/%0d/%0d expected %0d/%0d/%0d", mon_e.id,
                         p_raw, p_dmem, p_fl, mon_e.e_raw, mon_e.e_dmem, mon_e.e_fl);
            end
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        tick();
        repeat (2) @(posedge clk);
        // Reset held, then warm-up of exactly 4 cycles
        tick(); push(RST_O, RST_O);
        tick(); rst_n = 1'b1; push(RST_O, RST_O);
        repeat (3) begin tick(); push(RST_O, RST_O); end
        tick(); push(RUN_O, RUN_O);

        // Load-use on r5 as the producer walks EXE -> MEM -> WB
        tick(); rs_addr_id = 5'd5; rs_used_id = 1'b1; regw_addr_exe = 5'd5; wb_wen_exe = 1'b1;
        push(RAW_O, RAW_O);
        tick(); rs_addr_id = 5'd5; rs_used_id = 1'b1; regw_addr_mem = 5'd5; wb_wen_mem = 1'b1;
        push(RAW_O, RAW_O);
        tick(); rs_addr_id = 5'd5; rs_used_id = 1'b1; regw_addr_wb = 5'd5; wb_wen_wb = 1'b1;
        push(RAW_O, RUN_O);
        tick(); rs_addr_id = 5'd5; rs_used_id = 1'b1; push(RUN_O, RUN_O);
        // $0, unused rt, and non-writing producer never stall
        tick(); rs_used_id = 1'b1; wb_wen_exe = 1'b1; push(RUN_O, RUN_O);
        tick(); rt_addr_id = 5'd7; rt_used_id = 1'b1; regw_addr_mem = 5'd7; wb_wen_mem = 1'b1;
        push(RAW_O, RAW_O);
        tick(); rt_addr_id = 5'd7; regw_addr_mem = 5'd7; wb_wen_mem = 1'b1; push(RUN_O, RUN_O);
        tick(); rs_addr_id = 5'd9; rs_used_id = 1'b1; regw_addr_exe = 5'd9; push(RUN_O, RUN_O);

        // Branch flush, also winning over a pending RAW
        tick(); mem_valid = 1'b1; is_branch_mem = 1'b1; push(FLUSH_O, FLUSH_O);
        tick(); mem_valid = 1'b1; is_branch_mem = 1'b1;
        rs_addr_id = 5'd5; rs_used_id = 1'b1; regw_addr_exe = 5'd5; wb_wen_exe = 1'b1;
        push(FLUSH_O, FLUSH_O);
        tick(); push(RUN_O, RUN_O);

        // Data wait: 5 stalled cycles, then ack advances
        repeat (5) begin tick(); mem_acc(1'b0, 1'b0); push(WAIT_O, WAIT_O); end
        tick(); mem_acc(1'b1, 1'b0); push(RUN_O, RUN_O);
        tick(); push(RUN_O, RUN_O);
        // Ack in the entry cycle: no wait state
        tick(); mem_valid = 1'b1; mem_wen = 1'b1; dmem_ack = 1'b1; push(RUN_O, RUN_O);
        tick(); push(RUN_O, RUN_O);
        // Branch held during the wait, taken on ack
        repeat (2) begin tick(); mem_acc(1'b0, 1'b1); push(WAIT_O, WAIT_O); end
        tick(); mem_acc(1'b1, 1'b1); push(FLUSH_O, FLUSH_O);
        tick(); push(RUN_O, RUN_O);
        // RAW applies on the ack cycle
        tick(); mem_acc(1'b0, 1'b0); push(WAIT_O, WAIT_O);
        tick(); mem_acc(1'b1, 1'b0);
        rt_addr_id = 5'd3; rt_used_id = 1'b1; regw_addr_exe = 5'd3; wb_wen_exe = 1'b1;
        push(RAW_O, RAW_O);
        tick(); push(RUN_O, RUN_O);

        // Timeout with TIMEOUT=8: 8 stalled cycles, then abandon and advance
        repeat (8) begin tick(); mem_acc(1'b0, 1'b0); push(WAIT_O, WAIT_O); end
        tick(); mem_acc(1'b0, 1'b0); push(RUN_O, RUN_O);
        m_err = 1'b1;
        repeat (2) begin tick(); push(RUN_O, RUN_O); end
        tick(); mem_acc(1'b1, 1'b0); push(RUN_O, RUN_O);

        // Async reset between edges while in the wait state
        repeat (2) begin tick(); mem_acc(1'b0, 1'b0); push(WAIT_O, WAIT_O); end
        tick(); mem_acc(1'b0, 1'b0);
        #1 rst_n = 1'b0;
        m_err = 1'b0;
        push(RST_O, RST_O);
        tick(); push(RST_O, RST_O);
        tick(); rst_n = 1'b1; push(RST_O, RST_O);
        repeat (3) begin tick(); push(RST_O, RST_O); end
        tick(); push(RUN_O, RUN_O);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
